// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, constants and MISR step function for the adder BIST
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_t;

    // Feedback taps; the controller keeps only the low WIDTH+1 bits.
    localparam int unsigned MISR_POLY_DEFAULT = 32'h13;

    // Largest signature the step function handles (WIDTH up to 8).
    localparam int unsigned MISR_MAX_W = 9;

    // One MISR step on a signature of width+1 bits held right-aligned in a
    // MISR_MAX_W-bit word; bits above the signature are returned as zero.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] data,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = MISR_MAX_W'((10'd1 << (width + 1)) - 10'd1);
        nxt  = (sig << 1) & mask;
        if (sig[4'(width)]) begin
            nxt = nxt ^ (poly & mask);
        end
        return nxt ^ (data & mask);
    endfunction

endpackage

// File: rtl/rca_adder.sv
// rtl/rca_adder.sv - WIDTH-bit ripple-carry adder built from full-adder cells
//
// Ports:
//   a, b  : WIDTH-bit operands
//   cin   : carry-in
//   sum   : WIDTH-bit sum
//   cout  : carry-out of the top cell
module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/bist_adder_ctrl.sv
// rtl/bist_adder_ctrl.sv - exhaustive BIST controller around a ripple-carry adder
//
// Purpose: in test mode walks every {a,b,cin} pattern through the adder,
// checks each result against a behavioural sum, counts mismatches and
// compacts the adder outputs into a MISR signature. In normal mode the
// adder is driven from the functional inputs.
//
// Build option: BIST_FAULT_INJECT_EN adds inject_en/inject_bit/inject_val,
// which force one adder output bit to a stuck value in both modes.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   testmode            : rising edge starts a run, low selects normal mode
//   func_a/b/cin        : functional adder inputs
//   sum, cout           : adder outputs (combinational from the adder inputs)
//   pattern             : current test pattern {a,b,cin}
//   busy, done          : run in progress / run complete
//   fault_detected      : sticky mismatch flag for the current/last run
//   fail_count          : saturating mismatch count
//   signature           : MISR contents
module bist_adder_ctrl
    import bist_pkg::*;
#(
    parameter int          WIDTH      = 4,
    parameter int unsigned MISR_POLY  = MISR_POLY_DEFAULT,
    parameter int          FAIL_CNT_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    testmode,
    input  logic [WIDTH-1:0]        func_a,
    input  logic [WIDTH-1:0]        func_b,
    input  logic                    func_cin,
`ifdef BIST_FAULT_INJECT_EN
    input  logic                    inject_en,
    input  logic [$clog2(WIDTH+1)-1:0] inject_bit,
    input  logic                    inject_val,
`endif
    output logic [WIDTH-1:0]        sum,
    output logic                    cout,
    output logic [2*WIDTH:0]        pattern,
    output logic                    busy,
    output logic                    done,
    output logic                    fault_detected,
    output logic [FAIL_CNT_W-1:0]   fail_count,
    output logic [WIDTH:0]          signature
);

    localparam int PW = 2 * WIDTH + 1;
    localparam logic [WIDTH:0] POLY = (WIDTH + 1)'(MISR_POLY);

    bist_state_t           state_q, state_d;
    logic                  testmode_q;
    logic [PW-1:0]         pattern_q, pattern_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic [FAIL_CNT_W-1:0] fail_q, fail_d;
    logic [WIDTH:0]        sig_q, sig_d;

    logic [WIDTH-1:0]      cut_a, cut_b;
    logic                  cut_cin;
    logic [WIDTH-1:0]      raw_sum;
    logic                  raw_cout;
    logic [WIDTH:0]        cut_out;
    logic [WIDTH:0]        ref_out;
    logic [MISR_MAX_W-1:0] misr_full;
    logic [WIDTH:0]        misr_step;
    logic                  start;

    assign cut_a   = busy_q ? pattern_q[PW-1:WIDTH+1] : func_a;
    assign cut_b   = busy_q ? pattern_q[WIDTH:1]      : func_b;
    assign cut_cin = busy_q ? pattern_q[0]            : func_cin;

    rca_adder #(.WIDTH(WIDTH)) u_cut (
        .a    (cut_a),
        .b    (cut_b),
        .cin  (cut_cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

`ifdef BIST_FAULT_INJECT_EN
    always_comb begin
        cut_out = {raw_cout, raw_sum};
        for (int i = 0; i <= WIDTH; i++) begin
            if (inject_en && (int'(inject_bit) == i)) begin
                cut_out[i] = inject_val;
            end
        end
    end
`else
    assign cut_out = {raw_cout, raw_sum};
`endif

    assign sum  = cut_out[WIDTH-1:0];
    assign cout = cut_out[WIDTH];

    assign ref_out = {1'b0, cut_a} + {1'b0, cut_b} + {{WIDTH{1'b0}}, cut_cin};

    always_comb begin
        misr_full = misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(POLY),
                              MISR_MAX_W'(cut_out), WIDTH);
        misr_step = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            misr_step[i] = misr_full[i];
        end
    end

    assign start = testmode & ~testmode_q;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        fault_d   = fault_q;
        fail_d    = fail_q;
        sig_d     = sig_q;

        case (state_q)
            IDLE: begin
                pattern_d = '0;
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                if (!testmode) begin
                    state_d   = IDLE;
                    pattern_d = '0;
                end else begin
                    state_d   = RUN;
                    pattern_d = '0;
                    sig_d     = '0;
                    fail_d    = '0;
                    fault_d   = 1'b0;
                end
            end
            RUN: begin
                if (!testmode) begin
                    // Abort: results so far stay visible until the next INIT.
                    state_d   = IDLE;
                    pattern_d = '0;
                end else begin
                    sig_d     = misr_step;
                    if (cut_out != ref_out) begin
                        fault_d = 1'b1;
                        if (fail_q != '1) begin
                            fail_d = fail_q + 1'b1;
                        end
                    end
                    // All-ones wraps the counter back to 0 on the way to DONE.
                    pattern_d = pattern_q + 1'b1;
                    if (pattern_q == '1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!testmode) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pattern_d = '0;
            end
        endcase

        busy_d = (state_d == INIT) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            // Reset value high so a testmode level already high when reset
            // releases is not taken as a start; it must go low first.
            testmode_q <= 1'b1;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            fail_q     <= '0;
            sig_q      <= '0;
        end else begin
            state_q    <= state_d;
            testmode_q <= testmode;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            fail_q     <= fail_d;
            sig_q      <= sig_d;
        end
    end

    assign pattern        = pattern_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fault_detected = fault_q;
    assign fail_count     = fail_q;
    assign signature      = sig_q;

endmodule
